// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions used by the padder and the hasher.
// Holds the padder state encoding, block geometry and the padding marker word.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD,
    S_WAIT,
    S_WR,
    S_PAD,
    S_DONE
  } pad_state_t;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

  // Room for N words, the marker word and the two length words, rounded up to whole blocks.
  function automatic logic [15:0] padded_blocks(input logic [15:0] n);
    logic [16:0] sum;
    sum = {1'b0, n} + 17'd18;
    return 16'(sum / 17'(BLOCK_WORDS));
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Single-port synchronous memory bus shared by the padder and the hasher.
// Read data is valid the cycle after the memory samples the address.
interface sha256_padder_if;

  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/sha256_padder.sv
// Copies an N-word message and appends FIPS 180-4 padding, 3 cycles per copied word and 1 per pad word.
// Runs to completion once started; done holds until start drops.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            message_addr,
  input  logic [15:0]            message_words,
  input  logic [15:0]            padded_addr,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            num_blocks,
  sha256_padder_if.master        mem
);

  pad_state_t  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] n_q, n_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [16:0] total_q, total_d;

  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] nblk_q, nblk_d;

  logic [31:0] len_lo;
  assign len_lo = {11'd0, n_q, 5'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      total_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      nblk_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      total_q <= total_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      nblk_q  <= nblk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    src_d   = src_q;
    dst_d   = dst_q;
    total_d = total_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
    nblk_d  = nblk_q;

    unique case (state_q)
      S_IDLE: begin
        addr_d  = '0;
        wdata_d = '0;
        done_d  = 1'b0;
        error_d = 1'b0;
        nblk_d  = '0;
        if (start) begin
          n_d     = message_words;
          src_d   = message_addr;
          dst_d   = padded_addr;
          idx_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (n_q > MAX_WORDS) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          nblk_d  = padded_blocks(n_q);
          total_d = 17'(padded_blocks(n_q)) * 17'(BLOCK_WORDS);
          state_d = (n_q != '0) ? S_RD : S_PAD;
        end
      end
      S_RD: begin
        addr_d  = src_q + idx_q;
        state_d = S_WAIT;
      end
      // Address stays on the bus so read data is still valid during WR.
      S_WAIT: state_d = S_WR;
      S_WR: begin
        addr_d  = dst_q + idx_q;
        wdata_d = mem.mem_read_data;
        we_d    = 1'b1;
        idx_d   = idx_q + 16'd1;
        state_d = (({1'b0, idx_q} + 17'd1) < {1'b0, n_q}) ? S_RD : S_PAD;
      end
      S_PAD: begin
        addr_d = dst_q + idx_q;
        we_d   = 1'b1;
        idx_d  = idx_q + 16'd1;
        if ({1'b0, idx_q} == total_q - 17'd1) begin
          wdata_d = len_lo;
          state_d = S_DONE;
        end else if (idx_q == n_q) begin
          wdata_d = PAD_WORD;
        end else begin
          wdata_d = '0;
        end
      end
      // Guarantees done is seen for at least one cycle even if start already fell.
      S_DONE: begin
        if (!start && done_q) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done               = done_q;
  assign error              = error_q;
  assign num_blocks         = nblk_q;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = we_q;
  assign mem.mem_addr       = addr_q;
  assign mem.mem_write_data = wdata_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder: a queue-based reference model predicts every memory
// write and each job result; independent monitors compare what the DUT presents.
module tb_sha256_padder;

  localparam logic [15:0] MAXW = 16'd1024;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] nblk;
    logic        err;
    int          done_edge;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] message_words;
  logic [15:0] padded_addr;
  logic        done;
  logic        error;
  logic [15:0] num_blocks;

  sha256_padder_if bus();

  sha256_padder #(.MAX_WORDS(MAXW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .message_addr  (message_addr),
    .message_words (message_words),
    .padded_addr   (padded_addr),
    .done          (done),
    .error         (error),
    .num_blocks    (num_blocks),
    .mem           (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int          edge_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  wr_t         wq[$];
  res_t        rq[$];
  logic        done_prev = 1'b0;

  always @(posedge clk) begin
    bus.mem_read_data <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_write_data;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : write_monitor
    wr_t w;
    if (bus.mem_we) begin
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.mem_addr, bus.mem_write_data);
      end else begin
        w = wq.pop_front();
        check("write_addr", 64'(bus.mem_addr), 64'(w.addr));
        check("write_data", 64'(bus.mem_write_data), 64'(w.data));
      end
    end
  end

  always @(negedge clk) begin : done_monitor
    res_t r;
    if (done && !done_prev) begin
      if (rq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done rose at edge %0d, expected none", edge_cnt);
      end else begin
        r = rq.pop_front();
        check("num_blocks", 64'(num_blocks), 64'(r.nblk));
        check("error", 64'(error), 64'(r.err));
        check("done_edge", 64'(edge_cnt), 64'(r.done_edge));
      end
    end
    done_prev <= done;
  end

  // Reference padded image: message, marker, zeros up to 14 mod 16, then the 64-bit bit length.
  task automatic build_padded(input logic [15:0] src, input logic [15:0] n, output logic [31:0] pm[$]);
    pm = {};
    for (int k = 0; k < int'(n); k++) pm.push_back(mem[16'(src + 16'(k))]);
    pm.push_back(32'h8000_0000);
    while (pm.size() % 16 != 14) pm.push_back(32'h0);
    pm.push_back(32'h0);
    pm.push_back(32'(n) * 32);
  endtask

  task automatic launch(input logic [15:0] src, input logic [15:0] n, input logic [15:0] dst, output int s_edge);
    @(posedge clk); #1;
    message_addr  = src;
    message_words = n;
    padded_addr   = dst;
    start         = 1'b1;
    s_edge        = edge_cnt + 1;
  endtask

  task automatic run_job(input logic [15:0] src, input logic [15:0] n, input logic [15:0] dst, input int hold);
    logic [31:0] pm[$];
    logic [31:0] dst_before;
    int          s_edge;
    int          waited;
    res_t        r;
    for (int k = 0; k < int'(n); k++) mem[16'(src + 16'(k))] = $urandom;
    dst_before = mem[dst];
    if (n > MAXW) begin
      launch(src, n, dst, s_edge);
      r.nblk = '0; r.err = 1'b1; r.done_edge = s_edge + 2;
      rq.push_back(r);
    end else begin
      build_padded(src, n, pm);
      foreach (pm[k]) wq.push_back('{addr: 16'(dst + 16'(k)), data: pm[k]});
      launch(src, n, dst, s_edge);
      r.nblk = 16'(pm.size() / 16); r.err = 1'b0;
      r.done_edge = s_edge + 2 * int'(n) + pm.size() + 2;
      rq.push_back(r);
    end
    waited = 0;
    while (!done && waited < 6000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: done still low after %0d cycles, expected high", waited);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check("done_held", 64'(done), 64'(1));
    if (n > MAXW) check("dst_unchanged", 64'(mem[dst]), 64'(dst_before));
    start = 1'b0;
    @(posedge clk); #1;
    check("done_clear", 64'(done), 64'(0));
    check("error_clear", 64'(error), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_num_blocks"}, 64'(num_blocks), 64'(0));
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    check({tag, "_mem_write_data"}, 64'(bus.mem_write_data), 64'(0));
  endtask

  task automatic reset_mid_job();
    logic [31:0] pm[$];
    int          s_edge;
    for (int k = 0; k < 20; k++) mem[16'(16'h0100 + 16'(k))] = $urandom;
    build_padded(16'h0100, 16'd20, pm);
    for (int k = 0; k < 5; k++) wq.push_back('{addr: 16'(16'h0800 + 16'(k)), data: pm[k]});
    launch(16'h0100, 16'd20, 16'h0800, s_edge);
    // WR of word 5 occupies the cycle after edge s_edge+18.
    while (edge_cnt < s_edge + 18) begin
      @(posedge clk); #1;
    end
    check("pre_reset_num_blocks", 64'(num_blocks), 64'(2));
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    message_addr  = '0;
    message_words = '0;
    padded_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    run_job(16'h0100, 16'd20, 16'h0400, 3);
    check("n20_marker", 64'(mem[16'h0414]), 64'(32'h8000_0000));
    check("n20_zero", 64'(mem[16'h041E]), 64'(0));
    check("n20_len", 64'(mem[16'h041F]), 64'(32'h280));

    run_job(16'h0300, 16'd0, 16'h0500, 1);
    check("n0_marker", 64'(mem[16'h0500]), 64'(32'h8000_0000));
    check("n0_len", 64'(mem[16'h050F]), 64'(0));

    run_job(16'h0300, 16'd13, 16'h0600, 1);
    check("n13_len", 64'(mem[16'h060F]), 64'(32'h1A0));
    run_job(16'h0300, 16'd14, 16'h0700, 2);
    check("n14_marker", 64'(mem[16'h070E]), 64'(32'h8000_0000));
    check("n14_len", 64'(mem[16'h071F]), 64'(32'h1C0));

    run_job(16'h2000, 16'd1025, 16'h3000, 1);
    run_job(16'h4000, 16'd1024, 16'h5000, 1);

    reset_mid_job();
    run_job(16'h0100, 16'd20, 16'h0800, 1);

    run_job(16'h0200, 16'd20, 16'hFFF8, 4);
    check("wrap_len", 64'(mem[16'h0017]), 64'(32'h280));

    run_job(16'h0900, 16'd17, 16'h0900, 1);

    for (int j = 0; j < 6; j++)
      run_job(16'(16'h1000 + 16'(j * 256)), 16'($urandom_range(1, 40)),
              16'(16'h1800 + 16'(j * 256)), $urandom_range(1, 3));

    repeat (4) @(posedge clk);
    #1;
    check("writes_outstanding", 64'(wq.size()), 64'(0));
    check("results_outstanding", 64'(rq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
